// File: rtl/pipe_reg.sv
// Elastic register pipeline: depth_p stages with valid/ready handshake and bubble collapse.
// Optional occupancy counter output count_o when PIPE_REG_COUNT_EN is defined.
module pipe_reg #(
  parameter int                 width_p     = 8,
  parameter int                 depth_p     = 4,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(depth_p+1)-1:0] count_o
`endif
);

  logic [depth_p-1:0] r_valid;
  logic [width_p-1:0] r_data [depth_p];

  logic [depth_p-1:0] w_ready;
  logic [depth_p-1:0] w_valid_src;
  logic [width_p-1:0] w_data_src [depth_p];
  logic               w_acc;

  // A stage is ready if it or any stage downstream of it is empty, or the sink accepts.
  always_comb begin
    w_ready = '0;
    w_acc   = ready_i;
    for (int k = depth_p - 1; k >= 0; k--) begin
      w_acc      = w_acc | ~r_valid[k];
      w_ready[k] = w_acc;
    end
  end

  always_comb begin
    w_valid_src    = '0;
    w_valid_src[0] = valid_i;
    for (int k = 0; k < depth_p; k++) begin
      w_data_src[k] = data_i;
    end
    for (int k = 1; k < depth_p; k++) begin
      w_valid_src[k] = r_valid[k-1];
      w_data_src[k]  = r_data[k-1];
    end
  end

  // NOTE: non-blocking assignments here so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      // NOTE: data registers are reset as well so reset_val_p is observable on data_o.
      for (int k = 0; k < depth_p; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= reset_val_p;
      end
    end else if (en_i) begin
      for (int k = 0; k < depth_p; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_valid_src[k];
          r_data[k]  <= w_data_src[k];
        end
      end
    end
  end

  assign ready_o = w_ready[0] & en_i;
  assign valid_o = r_valid[depth_p-1] & en_i;
  assign data_o  = r_data[depth_p-1];

`ifdef PIPE_REG_COUNT_EN
  localparam int cnt_w_lp = $clog2(depth_p + 1);

  logic [cnt_w_lp-1:0] r_count;
  logic                w_in_xfer;
  logic                w_out_xfer;

  assign w_in_xfer  = valid_i & ready_o;
  assign w_out_xfer = valid_o & ready_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o = r_count;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg (width 8, depth 4, reset value 8'hA5).
// Count checks are active only when PIPE_REG_COUNT_EN is defined.
module tb_pipe_reg;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       en_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
`ifdef PIPE_REG_COUNT_EN
  logic [2:0] count_o;
`endif

  int n_checks = 0;
  int n_err    = 0;

  pipe_reg #(.width_p(8), .depth_p(4), .reset_val_p(8'hA5)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .en_i    (en_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef PIPE_REG_COUNT_EN
    ,
    .count_o (count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic       rdy;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] exp_seq [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_count(input string name, input logic [31:0] exp);
`ifdef PIPE_REG_COUNT_EN
    check(name, 32'(count_o), exp);
`else
    if (exp > 32'd4) $display("note: %s expectation out of range", name);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Stream 01..08 with the sink always ready, then drain.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 8'h01};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h02};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 8'h03};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 8'h04};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 8'h05};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h06};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h07};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};

    reset_i = 1'b1;
    en_i    = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    ready_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'hA5);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check_count("reset count_o", 32'd0);

    for (int i = 0; i < 12; i++) begin
      en_i    = vecs[i].en;
      valid_i = vecs[i].vld;
      ready_i = vecs[i].rdy;
      data_i  = vecs[i].data;
      #1;
      check($sformatf("stream[%0d] ready_o", i), 32'(ready_o), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("stream[%0d] valid_o", i), 32'(valid_o), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("stream[%0d] data_o", i), 32'(data_o), 32'(vecs[i].exp_data));
    end

    // Fill with the sink stalled, hold full, then simultaneous in/out.
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'(8'h10 + i);
      #1;
      check($sformatf("fill[%0d] ready_o", i), 32'(ready_o), 32'd1);
      tick();
    end
    check("full ready_o", 32'(ready_o), 32'd0);
    check("full valid_o", 32'(valid_o), 32'd1);
    check("full data_o", 32'(data_o), 32'h10);
    check_count("full count_o", 32'd4);
    data_i = 8'hEE;
    tick();
    check("full stall data_o", 32'(data_o), 32'h10);
    check("full stall ready_o", 32'(ready_o), 32'd0);
    check_count("full stall count_o", 32'd4);
    ready_i = 1'b1;
    data_i  = 8'h14;
    #1;
    check("full pass ready_o", 32'(ready_o), 32'd1);
    tick();
    check("full pass data_o", 32'(data_o), 32'h11);
    check_count("full pass count_o", 32'd4);
    valid_i = 1'b0;
    exp_seq = '{8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("drain[%0d] data_o", i), 32'(data_o), 32'(exp_seq[i]));
      check($sformatf("drain[%0d] valid_o", i), 32'(valid_o), 32'd1);
    end
    tick();
    check("drain empty valid_o", 32'(valid_o), 32'd0);

    // Bubble collapse with the sink stalled.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h20;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    valid_i = 1'b1;
    data_i  = 8'h21;
    tick();
    check("bubble first valid_o", 32'(valid_o), 32'd1);
    check("bubble first data_o", 32'(data_o), 32'h20);
    valid_i = 1'b0;
    tick();
    tick();
    check("bubble hold data_o", 32'(data_o), 32'h20);
    check_count("bubble count_o", 32'd2);
    ready_i = 1'b1;
    tick();
    check("bubble second data_o", 32'(data_o), 32'h21);
    check("bubble second valid_o", 32'(valid_o), 32'd1);
    tick();
    check("bubble empty valid_o", 32'(valid_o), 32'd0);

    // Global enable low freezes three held items.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h30;
    tick();
    data_i = 8'h31;
    tick();
    data_i = 8'h32;
    tick();
    valid_i = 1'b0;
    tick();
    en_i    = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h3F;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("freeze[%0d] ready_o", i), 32'(ready_o), 32'd0);
      check($sformatf("freeze[%0d] valid_o", i), 32'(valid_o), 32'd0);
      tick();
      check($sformatf("freeze[%0d] data_o", i), 32'(data_o), 32'h30);
    end
    check_count("freeze count_o", 32'd3);
    en_i    = 1'b1;
    valid_i = 1'b0;
    #1;
    check("resume valid_o", 32'(valid_o), 32'd1);
    check("resume data_o 0", 32'(data_o), 32'h30);
    tick();
    check("resume data_o 1", 32'(data_o), 32'h31);
    tick();
    check("resume data_o 2", 32'(data_o), 32'h32);
    tick();
    check("resume empty valid_o", 32'(valid_o), 32'd0);

    // Reset mid-operation discards in-flight items and the concurrent push.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h40;
    tick();
    data_i = 8'h41;
    tick();
    reset_i = 1'b1;
    data_i  = 8'h42;
    tick();
    reset_i = 1'b0;
    valid_i = 1'b0;
    check("midreset valid_o", 32'(valid_o), 32'd0);
    check("midreset data_o", 32'(data_o), 32'hA5);
    check("midreset ready_o", 32'(ready_o), 32'd1);
    check_count("midreset count_o", 32'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("postreset[%0d] valid_o", i), 32'(valid_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter width_p, default 8: data width in bits; SHALL be >= 1.
REQ-002 Parameter depth_p, default 4: number of register stages; SHALL be >= 1.
REQ-003 Parameter reset_val_p [width_p-1:0], default 0: value loaded into every stage data register on reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 en_i  input  1  global enable; low freezes the whole pipeline.
REQ-007 valid_i  input  1  upstream data valid.
REQ-008 data_i  input  width_p  upstream data.
REQ-009 ready_o  output  1  pipeline can accept data this cycle.
REQ-010 valid_o  output  1  last stage holds valid data.
REQ-011 data_o  output  width_p  last stage data register.
REQ-012 ready_i  input  1  downstream can accept data this cycle.
REQ-013 count_o  output  $clog2(depth_p+1)  number of valid stages; present only per REQ-030.

Function
REQ-014 Each stage k (0..depth_p-1) SHALL hold a valid flag and a width_p data register; stage 0 is the input side and stage depth_p-1 drives valid_o/data_o.
REQ-015 Stage k ready SHALL be (not valid[k]) OR ready of stage k+1; ready of stage depth_p is ready_i; ready_o is stage 0 ready AND en_i, combinationally.
REQ-016 Input transfer occurs when valid_i AND ready_o; output transfer occurs when valid_o AND ready_i.
REQ-017 When en_i is high and stage k ready, stage k SHALL load the valid flag and data of stage k-1, or of valid_i/data_i for k=0.
REQ-018 A stage that does not load SHALL hold its data register unchanged; data of a stage loading an invalid flag is don't-care but SHALL still be written (no gating required).
REQ-019 Bubbles SHALL collapse: an invalid stage accepts from upstream even while downstream is stalled.
REQ-020 Latency: an item accepted at edge N with no stalls SHALL appear on valid_o/data_o after edge N+depth_p-1; throughput one item per cycle.
REQ-021 Full (all depth_p stages valid, ready_i low): ready_o SHALL be 0; no data lost or overwritten.
REQ-022 Full with ready_i high: input and output transfer SHALL both occur in the same cycle; occupancy unchanged.
REQ-023 Ordering SHALL be strictly FIFO; no item duplicated or dropped.
REQ-024 en_i low: no state changes; ready_o SHALL be 0; valid_o SHALL be 0; data_o holds last-stage data.
REQ-025 valid_o and data_o SHALL be driven directly from last-stage registers (no combinational path from inputs).

Reset
REQ-026 On a rising clk edge with reset_i high, all valid flags SHALL clear and all data registers SHALL load reset_val_p, regardless of en_i.
REQ-027 After reset: valid_o=0, data_o=reset_val_p, count_o=0, ready_o=en_i.
REQ-028 Reset mid-operation SHALL discard all in-flight items; a transfer presented in the reset cycle SHALL be ignored.
REQ-029 Reset has priority over all other updates.

Configuration
REQ-030 Macro PIPE_REG_COUNT_EN: when defined, count_o exists and SHALL equal the number of set valid flags, updated with the flags (registered, +1/-1/0 per cycle, never exceeding depth_p); when undefined, count_o and its counter SHALL be absent and all other behaviour identical.

Verification (width_p=8, depth_p=4, reset_val_p=8'hA5)
REQ-031 Reset, en_i=1, no input -> valid_o=0, data_o=8'hA5, ready_o=1, count_o=0.
REQ-032 Stream 8'h01..8'h08 on consecutive cycles, ready_i=1 -> 8'h01 on data_o 3 cycles after its acceptance edge, then one item per cycle in order, ready_o never 0.
REQ-033 ready_i=0, push 8'h10..8'h13 -> ready_o=0 after 4th accept, count_o=4; raise ready_i with valid_i=1, data 8'h14 -> 8'h10 out and 8'h14 in same cycle, count_o stays 4.
REQ-034 Push 8'h20, idle 2 cycles, push 8'h21 with ready_i=0 -> both items collapse into stages 3 and 2; release -> 8'h20 then 8'h21 on consecutive cycles.
REQ-035 Pipeline holding 3 items, en_i=0 for 5 cycles with valid_i=1, ready_i=1 -> no transfers, ready_o=0, valid_o=0, count_o=3; en_i=1 resumes with original order.
REQ-036 Pipeline holding 2 items, assert reset_i with valid_i=1 -> next cycle valid_o=0, data_o=8'hA5, count_o=0; no item emerges later.
